// File: rtl/uart_tx_fifo_cfg.sv
// Configurable-frame UART transmitter (5-9 data bits, none/even/odd parity, 1-2 stop bits)
// fed by a small valid/ready input FIFO so queued words go out back-to-back.
module uart_tx_fifo_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_tx_valid,
  input  logic [DATA_W-1:0]             uart_tx_data,
  output logic                          uart_tx_ready,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic                          uart_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int CNT_W        = $clog2(BAUD_CNT_MAX);
  localparam int IDX_W        = $clog2(DATA_W);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int LVL_W        = PTR_W + 1;

  if (DATA_W < 5 || DATA_W > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BAUD_CNT_MAX < 2) begin : g_param_check
    $error("uart_tx_fifo_cfg: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    baud_cnt_q, baud_cnt_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                txd_q, txd_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic push, pop, bit_last, frame_end, par_bit;

  assign uart_tx_ready = (level_q != LVL_W'(FIFO_DEPTH));
  assign push          = uart_tx_valid && uart_tx_ready;
  assign bit_last      = (baud_cnt_q == CNT_W'(BAUD_CNT_MAX - 1));
  assign frame_end     = (state_q == S_STOP) && bit_last && (bit_idx_q == IDX_W'(STOP_BITS - 1));
  // Pop looks at the level before this cycle's push, so a fresh word waits one clk.
  assign pop           = (level_q != '0) && ((state_q == S_IDLE) || frame_end);
  assign par_bit       = (PARITY == 1) ? ^shreg_q : ~^shreg_q;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    txd_d      = txd_q;
    if (state_q != S_IDLE) begin
      baud_cnt_d = bit_last ? '0 : baud_cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE: txd_d = 1'b1;
      S_START: begin
        if (bit_last) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          txd_d     = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_last) begin
          if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
            bit_idx_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              txd_d   = par_bit;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            txd_d     = shreg_q[bit_idx_q + 1'b1];
          end
        end
      end
      S_PARITY: begin
        if (bit_last) begin
          state_d   = S_STOP;
          bit_idx_d = '0;
          txd_d     = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_last) begin
          if (bit_idx_q == IDX_W'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A pop overrides the frame tail so the next START follows the last stop clk directly.
    if (pop) begin
      state_d    = S_START;
      shreg_d    = mem_q[rd_ptr_q];
      txd_d      = 1'b0;
      baud_cnt_d = '0;
      bit_idx_d  = '0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= uart_tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      txd_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      txd_q      <= txd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = (state_q != S_IDLE);
  assign uart_tx_done = frame_end;
  assign fifo_level   = level_q;

endmodule
